// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle, MSB first.
// It holds the pipeline through stall and pulses ready when hi (remainder) and lo (quotient) are valid.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             annul,
  output logic             stall,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DZERO, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic             r_qneg;
  logic             r_rneg;

  logic             w_go;
  logic             w_last;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  assign w_go    = start & ~annul;
  assign w_last  = (r_cnt == CW'(WIDTH - 1));
  assign w_a_neg = signed_div & opa[WIDTH-1];
  assign w_b_neg = signed_div & opb[WIDTH-1];
  assign w_a_mag = w_a_neg ? -opa : opa;
  assign w_b_mag = w_b_neg ? -opb : opb;

  // Dividend shifts out of r_dvd into the partial remainder while quotient bits shift in.
  assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_dvs};
  assign w_qbit     = ~w_diff[WIDTH];
  assign w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_next = {r_dvd[WIDTH-2:0], w_qbit};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_go) w_next = (opb == '0) ? S_DZERO : S_RUN;
      S_RUN:   if (annul) w_next = S_IDLE;
               else if (w_last) w_next = S_DONE;
      S_DZERO: w_next = annul ? S_IDLE : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    stall = start & ~annul & (r_state != S_DONE);
    ready = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_rem  <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go && opb != '0) begin
            r_dvd  <= w_a_mag;
            r_dvs  <= w_b_mag;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_qneg <= w_a_neg ^ w_b_neg;
            r_rneg <= w_a_neg;
          end
        end
        S_RUN: begin
          r_dvd <= w_quo_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last && !annul) begin
            lo <= r_qneg ? -w_quo_next : w_quo_next;
            hi <= r_rneg ? -w_rem_next : w_rem_next;
          end
        end
        S_DZERO: begin
          if (!annul) begin
            hi <= '0;
            lo <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed and random checks of div_sequencer timing, results, annul and reset behaviour
// against an arithmetic reference model.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        annul;
  logic        stall;
  logic        ready;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_hi  = '0;
  logic [31:0] exp_lo  = '0;

  div_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .opa(opa), .opb(opb), .annul(annul),
    .stall(stall), .ready(ready), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Sign/magnitude division with truncation toward zero; remainder takes the dividend's sign.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit s,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, ma, mb, q0, r0;
    if (b == 32'd0) begin
      q = '0;
      r = '0;
      return;
    end
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    q0 = ma / mb;
    r0 = ma % mb;
    if ((sa < 0) != (sb < 0)) q0 = -q0;
    if (sa < 0) r0 = -r0;
    q = q0[31:0];
    r = r0[31:0];
  endfunction

  // Entered at posedge+1 of the cycle where start is first presented (cycle 0).
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                         input int annul_cyc, input bit annul_done, input int rst_cyc);
    logic [31:0] mq, mr;
    int lat;
    lat = (b == 32'd0) ? 2 : 33;
    model(a, b, s, mq, mr);
    for (int cyc = 0; cyc <= lat; cyc++) begin
      if (cyc == 0) begin
        start = 1'b1; opa = a; opb = b; signed_div = s;
      end else if (cyc < lat) begin
        opa = $urandom; opb = $urandom; signed_div = 1'($urandom);
      end
      if (cyc == annul_cyc) annul = 1'b1;
      if (cyc == lat && annul_done) annul = 1'b1;
      #1;
      chk($sformatf("stall c%0d %h/%h", cyc, a, b), {31'd0, stall},
          {31'd0, (cyc != annul_cyc) && (cyc < lat)});
      chk($sformatf("ready c%0d %h/%h", cyc, a, b), {31'd0, ready}, {31'd0, cyc == lat});
      if (cyc == lat) begin
        exp_lo = mq;
        exp_hi = mr;
      end
      if (cyc == 0 || cyc == lat || cyc == annul_cyc) begin
        chk($sformatf("lo c%0d %h/%h s%0d", cyc, a, b, s), lo, exp_lo);
        chk($sformatf("hi c%0d %h/%h s%0d", cyc, a, b, s), hi, exp_hi);
      end
      if (cyc == annul_cyc) begin
        tick();
        annul = 1'b0; start = 1'b0;
        #1;
        chk("annul ready", {31'd0, ready}, 32'd0);
        chk("annul stall", {31'd0, stall}, 32'd0);
        chk("annul lo held", lo, exp_lo);
        chk("annul hi held", hi, exp_hi);
        tick();
        return;
      end
      if (cyc == rst_cyc) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_lo = '0;
        exp_hi = '0;
        return;
      end
      tick();
    end
    start = 1'b0; annul = 1'b0;
    #1;
    chk("post ready", {31'd0, ready}, 32'd0);
    chk("post stall", {31'd0, stall}, 32'd0);
    chk("post lo held", lo, exp_lo);
    chk("post hi held", hi, exp_hi);
    tick();
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; opa = '0; opb = '0; annul = 1'b0;
    tick();
    tick();
    chk("reset ready", {31'd0, ready}, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset hi", hi, 32'd0);
    rst = 1'b0;
    tick();
    chk("after reset stall", {31'd0, stall}, 32'd0);

    run_div(32'd100, 32'd7, 1'b0, -1, 1'b0, -1);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, -1, 1'b0, -1);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, 1'b0, -1);
    run_div(32'd5, 32'd0, 1'b0, -1, 1'b0, -1);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0, -1, 1'b0, -1);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, 1'b0, -1);

    run_div(32'd1000, 32'd3, 1'b0, 10, 1'b0, -1);
    run_div(32'd9, 32'd0, 1'b1, 1, 1'b0, -1);

    start = 1'b1; annul = 1'b1; opa = 32'd50; opb = 32'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("idle annul stall", {31'd0, stall}, 32'd0);
      tick();
    end
    start = 1'b0; annul = 1'b0;
    tick();

    run_div(32'hDEAD_BEEF, 32'h0000_1234, 1'b1, -1, 1'b1, -1);
    run_div(32'd77, 32'd0, 1'b0, -1, 1'b1, -1);

    run_div(32'd12345, 32'd67, 1'b0, -1, 1'b0, 15);
    run_div(32'hFFFF_FF00, 32'hFFFF_FFF0, 1'b1, -1, 1'b0, -1);

    for (int i = 0; i < 24; i++) begin
      ra = (i % 7 == 3) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom_range(0, 3);
        1:       rb = -$urandom_range(1, 3);
        default: rb = $urandom;
      endcase
      run_div(ra, rb, 1'($urandom), -1, 1'b0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
